// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: lane-wise SIMD ALU (8/16/32-bit lanes) with optional signed
// saturation, a single-cycle path for simple ops and a multi-cycle multiply
// path, behind a valid/ready handshake with a registered result stage.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no result held; ready for a new op
// MUL_BUSY | multiply accepted, waiting out MUL_LATENCY; not ready
// HOLD     | result valid on res/ovf; ready only when consumer takes it
module simd_alu_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [3:0]            op,
  input  logic [1:0]            lane_mode,
  input  logic                  sat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  ovf
);

  localparam int NCHUNK = DATA_WIDTH / 32;
  localparam int CW     = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic                  ovf_q;
  logic [DATA_WIDTH-1:0] mres_q;
  logic                  movf_q;

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_ovf;
  logic                  accept;
  logic                  is_mul;

  // One lane of width w (8/16/32) held in the low bits of 32-bit operands.
  // Arithmetic is done in 64-bit signed so the saturation compare sees the
  // true (unwrapped) result. Returns {clamped, result}.
  function automatic logic [32:0] lane_calc(input logic [31:0] la,
                                            input logic [31:0] lb,
                                            input logic [5:0]  w,
                                            input logic [3:0]  opc,
                                            input logic        sat_en);
    logic [63:0]        mask;
    logic [63:0]        ua;
    logic [63:0]        ub;
    logic [6:0]         sh;
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sr;
    logic signed [63:0] smax;
    logic signed [63:0] smin;
    logic [4:0]         amt;
    logic               clamp;
    mask  = (64'd1 << w) - 64'd1;
    ua    = {32'b0, la} & mask;
    ub    = {32'b0, lb} & mask;
    sh    = 7'd64 - {1'b0, w};
    sa    = $signed(ua << sh) >>> sh;
    sb    = $signed(ub << sh) >>> sh;
    smax  = $signed(mask >> 1);
    smin  = -smax - 64'sd1;
    // lane widths are powers of two, so w-1 masks the low log2(w) bits
    amt   = ub[4:0] & (w[4:0] - 5'd1);
    sr    = '0;
    clamp = 1'b0;
    case (opc)
      4'd0:    sr = sa + sb;
      4'd1:    sr = sa - sb;
      4'd2:    sr = $signed(ua << amt);
      4'd3:    sr = $signed(ua >> amt);
      4'd4:    sr = sa >>> amt;
      4'd5:    sr = sa * sb;
      4'd6:    sr = $signed(ua * ub);
      4'd7:    sr = (sa < sb) ? sa : sb;
      4'd8:    sr = (sa > sb) ? sa : sb;
      default: sr = '0;
    endcase
    if (sat_en && (opc == 4'd0 || opc == 4'd1 || opc == 4'd5)) begin
      if (sr > smax) begin
        sr    = smax;
        clamp = 1'b1;
      end else if (sr < smin) begin
        sr    = smin;
        clamp = 1'b1;
      end
    end
    return {clamp, sr[31:0] & mask[31:0]};
  endfunction

  // Full-width result: every 32-bit chunk is split into lanes per lane_mode.
  function automatic logic [DATA_WIDTH:0] alu(input logic [DATA_WIDTH-1:0] av,
                                              input logic [DATA_WIDTH-1:0] bv,
                                              input logic [3:0]            opc,
                                              input logic [1:0]            mode,
                                              input logic                  s);
    logic [DATA_WIDTH-1:0] r;
    logic                  o;
    logic [32:0]           t;
    r = '0;
    o = 1'b0;
    for (int c = 0; c < NCHUNK; c++) begin
      case (mode)
        2'b00: begin
          for (int i = 0; i < 4; i++) begin
            t = lane_calc({24'b0, av[c*32+i*8 +: 8]}, {24'b0, bv[c*32+i*8 +: 8]},
                          6'd8, opc, s);
            r[c*32+i*8 +: 8] = t[7:0];
            o = o | t[32];
          end
        end
        2'b01: begin
          for (int i = 0; i < 2; i++) begin
            t = lane_calc({16'b0, av[c*32+i*16 +: 16]}, {16'b0, bv[c*32+i*16 +: 16]},
                          6'd16, opc, s);
            r[c*32+i*16 +: 16] = t[15:0];
            o = o | t[32];
          end
        end
        default: begin
          t = lane_calc(av[c*32 +: 32], bv[c*32 +: 32], 6'd32, opc, s);
          r[c*32 +: 32] = t[31:0];
          o = o | t[32];
        end
      endcase
    end
    return {o, r};
  endfunction

  // Lane ALU on the live inputs; its output is only captured on acceptance.
  always_comb begin
    {alu_ovf, alu_res} = alu(a, b, op, lane_mode, sat);
  end

  // Handshake: HOLD can take a new op in the same cycle the result leaves.
  always_comb begin
    in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    accept   = in_valid && in_ready;
    is_mul   = (op == 4'd5) || (op == 4'd6);
  end

  // Sequencer, latency down-counter and registered result stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      mres_q      <= '0;
      movf_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            if (is_mul && (MUL_LATENCY > 1)) begin
              // product is computed now so later operand changes cannot leak in
              state_q     <= MUL_BUSY;
              cnt_q       <= CNT_LOAD;
              out_valid_q <= 1'b0;
              mres_q      <= alu_res;
              movf_q      <= alu_ovf;
            end else begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              res_q       <= alu_res;
              ovf_q       <= alu_ovf;
            end
          end else if ((state_q == HOLD) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        MUL_BUSY: begin
          cnt_q <= cnt_q - CNT_ONE;
          // the accept edge already counts as the first latency edge, so
          // the terminal count is 1 rather than 0
          if (cnt_q == CNT_ONE) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            res_q       <= mres_q;
            ovf_q       <= movf_q;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Bench for simd_alu_pipe: directed cases with literal results, then a long
// randomized run compared every cycle against a transaction-level model.
module tb_simd_alu_pipe;
  localparam int DW = 32;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic [3:0]    op = '0;
  logic [1:0]    lane_mode = '0;
  logic          sat = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] res;
  logic          ovf;

  int n_checks = 0;
  int n_pass   = 0;
  logic cmp_en = 1'b0;

  // model state
  logic          m_valid = 1'b0;
  int            m_wait  = 0;
  logic [DW:0]   m_out   = '0;
  logic [DW:0]   m_pend  = '0;
  logic          m_acc;

  always #5 clk = ~clk;

  simd_alu_pipe #(.DATA_WIDTH(DW), .MUL_LATENCY(ML)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .lane_mode(lane_mode), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference: plain integer arithmetic per lane, result folded back in.
  function automatic logic [DW:0] ref_alu(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                          input logic [3:0] o, input logic [1:0] m,
                                          input logic s);
    int w;
    int amt;
    longint unsigned span, mask, ua, ub;
    longint sa, sb, v, vmax, vmin;
    logic [DW-1:0] r, piece;
    logic ov;
    w    = (m == 2'd0) ? 8 : (m == 2'd1) ? 16 : 32;
    span = 64'd1 << w;
    mask = span - 1;
    vmax = longint'(span / 2) - 1;
    vmin = -longint'(span / 2);
    r = '0;
    ov = 1'b0;
    for (int i = 0; i < DW / w; i++) begin
      ua  = longint'(av >> (i * w)) & mask;
      ub  = longint'(bv >> (i * w)) & mask;
      sa  = (ua > longint'(vmax)) ? longint'(ua) - longint'(span) : longint'(ua);
      sb  = (ub > longint'(vmax)) ? longint'(ub) - longint'(span) : longint'(ub);
      amt = int'(ub % longint'(w));
      case (o)
        4'd0:    v = sa + sb;
        4'd1:    v = sa - sb;
        4'd2:    v = longint'(ua << amt);
        4'd3:    v = longint'(ua >> amt);
        4'd4:    v = sa >>> amt;
        4'd5:    v = sa * sb;
        4'd6:    v = longint'(ua * ub);
        4'd7:    v = (sa < sb) ? sa : sb;
        4'd8:    v = (sa > sb) ? sa : sb;
        default: v = 0;
      endcase
      if (s && (o == 4'd0 || o == 4'd1 || o == 4'd5)) begin
        if (v > vmax) begin v = vmax; ov = 1'b1; end
        else if (v < vmin) begin v = vmin; ov = 1'b1; end
      end
      piece = DW'(longint'(v) & longint'(mask));
      r = r | (piece << (i * w));
    end
    return {ov, r};
  endfunction

  function automatic logic m_rdy();
    return (m_wait == 0) && (!m_valid || out_ready);
  endfunction

  // Transaction model: result appears 1 edge (simple) or ML edges (multiply)
  // after acceptance and stays until the consumer takes it.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_valid = 1'b0; m_wait = 0; m_out = '0;
    end else begin
      m_acc = in_valid && m_rdy();
      if (m_acc) begin
        if (op == 4'd5 || op == 4'd6) begin
          m_pend = ref_alu(a, b, op, lane_mode, sat);
          m_wait = ML - 1;
          if (m_wait == 0) begin m_valid = 1'b1; m_out = m_pend; end
          else m_valid = 1'b0;
        end else begin
          m_out = ref_alu(a, b, op, lane_mode, sat);
          m_valid = 1'b1;
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin m_valid = 1'b1; m_out = m_pend; end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(posedge clk);
    #2;
    if (cmp_en) begin
      chk("cyc_in_ready", in_ready, m_rdy());
      chk("cyc_out_valid", out_valid, m_valid);
      chk("cyc_res", res, m_out[DW-1:0]);
      if (m_valid) chk("cyc_ovf", ovf, m_out[DW]);
    end
  end

  task automatic send(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic [3:0] o,
                      input logic [1:0] m, input logic s);
    int n = 0;
    @(negedge clk);
    a = av; b = bv; op = o; lane_mode = m; sat = s; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
    chk("accept_timeout", 64'(n < 20), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic expect_res(input string name, input logic [DW-1:0] er, input logic eo,
                            input int lat);
    int n = 0;
    while (!out_valid && n < 20) begin
      chk({name, "_busy_ready"}, in_ready, 1'b0);
      @(posedge clk); #1; n++;
    end
    chk({name, "_lat"}, 64'(n), 64'(lat));
    chk(name, res, er);
    chk({name, "_ovf"}, ovf, eo);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // pin the model with hand-computed values
    chk("ref_add8",    ref_alu(32'h7F01FF80, 32'h01010101, 4'd0, 2'd0, 1'b0), {1'b0, 32'h80020081});
    chk("ref_add8sat", ref_alu(32'h7F01FF80, 32'h01010101, 4'd0, 2'd0, 1'b1), {1'b1, 32'h7F020081});
    chk("ref_mul16",   ref_alu(32'hFFFE0003, 32'h00050004, 4'd5, 2'd1, 1'b0), {1'b0, 32'hFFF6000C});
    chk("ref_sra8",    ref_alu(32'h80F00408, 32'h01020304, 4'd4, 2'd0, 1'b0), {1'b0, 32'hC0FC0000});
    chk("ref_op12",    ref_alu(32'hDEADBEEF, 32'h12345678, 4'd12, 2'd2, 1'b1), {1'b0, 32'h0});
    chk("ref_umul8",   ref_alu(32'h10FF0302, 32'h10FF0505, 4'd6, 2'd0, 1'b1), {1'b0, 32'h00010F0A});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_res", res, 32'h0);
    chk("rst_ovf", ovf, 1'b0);

    send(32'h7F01FF80, 32'h01010101, 4'd0, 2'd0, 1'b0);
    expect_res("add8", 32'h80020081, 1'b0, 0);
    send(32'h7F01FF80, 32'h01010101, 4'd0, 2'd0, 1'b1);
    expect_res("add8_sat", 32'h7F020081, 1'b1, 0);
    send(32'hFFFE0003, 32'h00050004, 4'd5, 2'd1, 1'b0);
    expect_res("mul16", 32'hFFF6000C, 1'b0, ML - 1);
    send(32'h80F00408, 32'h01020304, 4'd4, 2'd0, 1'b0);
    expect_res("sra8", 32'hC0FC0000, 1'b0, 0);
    send(32'hDEADBEEF, 32'h12345678, 4'd12, 2'd2, 1'b1);
    expect_res("op12", 32'h0, 1'b0, 0);

    // back-pressure, then take-and-accept in the same cycle
    send(32'h00000005, 32'h00000007, 4'd0, 2'd2, 1'b0);
    out_ready = 1'b0;
    expect_res("hold_add", 32'h0000000C, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_res", res, 32'h0000000C);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    a = 32'h1; b = 32'h2; op = 4'd0; lane_mode = 2'd2; sat = 1'b0; in_valid = 1'b1;
    #1;
    chk("pass_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pass_valid", out_valid, 1'b1);
    chk("pass_res", res, 32'h00000003);

    // reset during a multiply
    send(32'h00000003, 32'h00000004, 4'd5, 2'd2, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_res", res, 32'h0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_result", out_valid, 1'b0);
      chk("mrst_ready", in_ready, 1'b1);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom % 3) != 0;
      a         = $urandom;
      b         = $urandom;
      op        = (($urandom % 8) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      lane_mode = 2'($urandom);
      sat       = 1'($urandom);
      out_ready = ($urandom % 4) != 0;
      if (($urandom % 400) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #3;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/simd_alu_pipe.md
SIMD_ALU_PIPE -- requirements
Module: simd_alu_pipe

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the operand/result width; it SHALL be a multiple of 32.
REQ-002 The module SHALL have parameter MUL_LATENCY, default 2, giving accept-to-result cycles for multiply ops; it SHALL be at least 1.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: an operation is presented.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block can accept an operation this cycle.
REQ-007 The module SHALL have port a, input, DATA_WIDTH bits: first operand.
REQ-008 The module SHALL have port b, input, DATA_WIDTH bits: second operand, or per-lane shift amounts.
REQ-009 The module SHALL have port op, input, 4 bits: operation select.
REQ-010 The module SHALL have port lane_mode, input, 2 bits: 00 = 8-bit lanes, 01 = 16-bit lanes, 10 and 11 = 32-bit lanes.
REQ-011 The module SHALL have port sat, input, 1 bit: signed saturation enable.
REQ-012 The module SHALL have port out_valid, output, 1 bit: res and ovf hold a result.
REQ-013 The module SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-014 The module SHALL have port res, output, DATA_WIDTH bits: registered result.
REQ-015 The module SHALL have port ovf, output, 1 bit: at least one lane saturated in this result.

Function
REQ-016 An operation SHALL be accepted on a rising edge where in_valid && in_ready; a, b, op, lane_mode and sat SHALL be captured at that edge.
REQ-017 All ops SHALL be lane-wise and independent per lane; no carry or shift SHALL cross lane boundaries.
REQ-018 op encoding SHALL be: 0 add, 1 sub, 2 sll, 3 srl, 4 sra, 5 signed multiply (low lane bits), 6 unsigned multiply (low lane bits), 7 signed min, 8 signed max; op values 9-15 SHALL produce res = 0 with ovf = 0.
REQ-019 For shift ops, the shift amount SHALL be the low log2(lane width) bits of the matching b lane.
REQ-020 With sat = 0, add, sub and mul SHALL wrap modulo 2^lane width.
REQ-021 With sat = 1, add, sub and signed mul SHALL clamp to the signed lane range [-2^(w-1), 2^(w-1)-1] and set ovf when any lane clamps; sat SHALL be ignored for all other ops.
REQ-022 The block SHALL implement an FSM with states IDLE, MUL_BUSY and HOLD.
REQ-023 IDLE: in_ready = 1 and out_valid = 0; accepting a non-multiply op SHALL go to HOLD; accepting a multiply op SHALL go to MUL_BUSY.
REQ-024 Non-multiply latency SHALL be 1: out_valid rises on the edge after acceptance.
REQ-025 MUL_BUSY: in_ready = 0; a down-counter SHALL load MUL_LATENCY-1 at acceptance, and out_valid SHALL rise exactly MUL_LATENCY edges after acceptance (entering HOLD).
REQ-026 For MUL_LATENCY = 1, the block SHALL go directly from acceptance to HOLD.
REQ-027 HOLD: out_valid = 1 and in_ready = out_ready (combinational).
REQ-028 HOLD with out_ready = 0 SHALL keep res and ovf stable.
REQ-029 HOLD with out_ready = 1 and no new op SHALL go to IDLE.
REQ-030 HOLD with out_ready = 1 and a new op accepted in the same cycle SHALL load the new result (non-multiply, staying in HOLD) or go to MUL_BUSY (multiply), so that non-multiply throughput is 1 per cycle.
REQ-031 While out_valid = 0, res SHALL retain its last value.
REQ-032 Changes on a or b while in MUL_BUSY SHALL NOT affect the pending result.

Reset
REQ-033 While rst_n = 0, the block SHALL force state = IDLE, out_valid = 0, res = 0, ovf = 0 and counter = 0, asynchronously.
REQ-034 Asserting rst_n = 0 during MUL_BUSY or HOLD SHALL discard the operation, with no result emitted after release.
REQ-035 in_ready SHALL be 1 during the first cycle after reset release.

Verification
REQ-036 Lane-8 add, sat = 0, a = 0x7F01FF80, b = 0x01010101 SHALL give res = 0x80020081 and ovf = 0 one cycle after acceptance; the same op with sat = 1 SHALL give res = 0x7F020081 and ovf = 1.
REQ-037 Lane-16 op 5, MUL_LATENCY = 2, a = 0xFFFE0003, b = 0x00050004 SHALL give res = 0xFFF6000C, with out_valid exactly 2 edges after acceptance and in_ready = 0 in between.
REQ-038 Lane-8 sra, a = 0x80F00408, b = 0x01020304 SHALL give res = 0xC0FC0000.
REQ-039 Holding out_ready = 0 for 3 cycles after a result SHALL keep res stable with in_ready = 0; raising out_ready together with in_valid (add, lane 32, a = 1, b = 2) SHALL keep out_valid = 1 and produce res = 0x00000003 on the next edge.
REQ-040 Pulsing rst_n low one cycle into a multiply SHALL force out_valid = 0 and res = 0 immediately; no result SHALL appear afterwards, and in_ready = 1 after release.
REQ-041 Lane-32 op 12 SHALL give res = 0 and ovf = 0.
